// File: rtl/timer_evt_ctrl.sv
// Timer event controller: arms a downstream Timer, tracks end-of-count events,
// raises an acknowledgeable interrupt and counts events missed while one is pending.
module timer_evt_ctrl #(
    parameter int N = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Pwr_off,
    input  logic         Wr_en,
    input  logic [1:0]   Wr_addr,
    input  logic [N-1:0] Wr_data,
    input  logic         Tmr_end,
    input  logic         Irq_ack,
    output logic         Tmr_en,
    output logic         Tmr_rst,
    output logic [N-1:0] Tmr_load,
    output logic         Irq,
    output logic [3:0]   Ovf_cnt,
    output logic         Busy,
    output logic [1:0]   Dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_LOAD = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_STOP = 2'd2;

    state_t       state_q, state_d;
    logic [N-1:0] load_q, load_d;
    logic         periodic_q, periodic_d;
    logic         irq_en_q, irq_en_d;
    logic         pend_q, pend_d;
    logic [3:0]   ovf_q, ovf_d;
    logic         irq_q, irq_d;

    // Write strobe: one single-cycle write per clock, no backpressure.
    // Power-off masks every write; reserved address 3 decodes to nothing.
    logic wr_load, wr_ctrl, wr_stop, start, evt;

    always_comb begin
        wr_load = Wr_en && !Pwr_off && (Wr_addr == ADDR_LOAD);
        wr_ctrl = Wr_en && !Pwr_off && (Wr_addr == ADDR_CTRL);
        wr_stop = Wr_en && !Pwr_off && (Wr_addr == ADDR_STOP);
        start   = wr_ctrl && Wr_data[0];
        evt     = (state_q == S_RUN) && Tmr_end && !Pwr_off;
    end

    // Configuration registers
    always_comb begin
        load_d     = load_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        if (wr_load) begin
            load_d = Wr_data;
        end
        if (wr_ctrl) begin
            periodic_d = Wr_data[1];
            irq_en_d   = Wr_data[2];
        end
    end

    // Next-state logic; write commands override the normal flow, power-off overrides all.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_ARM:  state_d = S_RUN;
            S_RUN: begin
                if (Tmr_end) begin
                    state_d = periodic_q ? S_ARM : S_DONE;
                end
            end
            S_DONE: begin
                if (Irq_ack && pend_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d = S_ARM;
        end
        if (wr_stop) begin
            state_d = S_IDLE;
        end
        if (Pwr_off) begin
            state_d = S_IDLE;
        end
    end

    // A new event wins over a same-cycle acknowledge so it is never lost.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (evt) begin
            pend_d = 1'b1;
        end else if (Irq_ack) begin
            pend_d = 1'b0;
        end
        if (start) begin
            ovf_d = 4'd0;
        end else if (evt && pend_q && !Irq_ack && (ovf_q != 4'd15)) begin
            ovf_d = ovf_q + 4'd1;
        end
        if (Pwr_off) begin
            pend_d = 1'b0;
            ovf_d  = 4'd0;
        end
        irq_d = pend_d && irq_en_d;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            load_q     <= '0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            pend_q     <= 1'b0;
            ovf_q      <= 4'd0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
        end
    end

    // Timer restart follows reset so both blocks come out of reset together.
    always_comb begin
        Tmr_en    = (state_q == S_RUN) && !Pwr_off;
        Tmr_rst   = Rst || (state_q == S_ARM);
        Tmr_load  = load_q;
        Irq       = irq_q;
        Ovf_cnt   = ovf_q;
        Busy      = (state_q != S_IDLE);
        Dbg_state = state_q;
    end

endmodule

// File: tb/tb_timer_evt_ctrl.sv
// Directed bench for timer_evt_ctrl: one-shot, periodic, overflow, collision,
// abort, reserved write, reset and power-off sequences.
module tb_timer_evt_ctrl;

    localparam int N = 32;
    localparam logic [1:0] A_LOAD = 2'd0;
    localparam logic [1:0] A_CTRL = 2'd1;
    localparam logic [1:0] A_STOP = 2'd2;
    localparam logic [1:0] A_RSVD = 2'd3;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         Pwr_off = 1'b0;
    logic         Wr_en = 1'b0;
    logic [1:0]   Wr_addr = 2'd0;
    logic [N-1:0] Wr_data = '0;
    logic         Tmr_end = 1'b0;
    logic         Irq_ack = 1'b0;
    logic         Tmr_en, Tmr_rst, Irq, Busy;
    logic [N-1:0] Tmr_load;
    logic [3:0]   Ovf_cnt;
    logic [1:0]   Dbg_state;

    int checks = 0;
    int errors = 0;
    int irq_pulses = 0;

    timer_evt_ctrl #(.N(N)) dut (
        .Clk(Clk), .Rst(Rst), .Pwr_off(Pwr_off), .Wr_en(Wr_en), .Wr_addr(Wr_addr),
        .Wr_data(Wr_data), .Tmr_end(Tmr_end), .Irq_ack(Irq_ack), .Tmr_en(Tmr_en),
        .Tmr_rst(Tmr_rst), .Tmr_load(Tmr_load), .Irq(Irq), .Ovf_cnt(Ovf_cnt),
        .Busy(Busy), .Dbg_state(Dbg_state)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [N-1:0] data);
        Wr_en = 1'b1;
        Wr_addr = addr;
        Wr_data = data;
        tick();
        Wr_en = 1'b0;
        Wr_data = '0;
    endtask

    task automatic pulse_end();
        Tmr_end = 1'b1;
        tick();
        Tmr_end = 1'b0;
    endtask

    task automatic pulse_ack();
        Irq_ack = 1'b1;
        tick();
        Irq_ack = 1'b0;
    endtask

    initial begin
        // Reset
        #1;
        check("rst_tmr_rst_during", 32'(Tmr_rst), 1);
        tick();
        check("rst_tmr_en", 32'(Tmr_en), 0);
        check("rst_irq", 32'(Irq), 0);
        check("rst_ovf", 32'(Ovf_cnt), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_load", Tmr_load, 0);
        check("rst_state", 32'(Dbg_state), 32'(ST_IDLE));
        Rst = 1'b0;
        tick();
        check("rst_release_tmr_rst", 32'(Tmr_rst), 0);

        // One-shot
        wr(A_LOAD, 32'd3);
        check("os_load", Tmr_load, 3);
        check("os_idle_after_load", 32'(Busy), 0);
        wr(A_CTRL, 32'b101);
        check("os_arm_tmr_rst", 32'(Tmr_rst), 1);
        check("os_arm_tmr_en", 32'(Tmr_en), 0);
        check("os_arm_state", 32'(Dbg_state), 32'(ST_ARM));
        check("os_arm_busy", 32'(Busy), 1);
        tick();
        check("os_run_tmr_en", 32'(Tmr_en), 1);
        check("os_run_tmr_rst", 32'(Tmr_rst), 0);
        tick();
        tick();
        tick();
        check("os_run_irq_before_end", 32'(Irq), 0);
        pulse_end();
        check("os_done_irq", 32'(Irq), 1);
        check("os_done_tmr_en", 32'(Tmr_en), 0);
        check("os_done_state", 32'(Dbg_state), 32'(ST_DONE));
        check("os_done_ovf", 32'(Ovf_cnt), 0);
        tick();
        check("os_done_holds", 32'(Dbg_state), 32'(ST_DONE));
        pulse_ack();
        check("os_ack_irq", 32'(Irq), 0);
        check("os_ack_busy", 32'(Busy), 0);

        // Periodic, each event acknowledged
        wr(A_CTRL, 32'b111);
        check("per_arm_tmr_rst", 32'(Tmr_rst), 1);
        tick();
        check("per_run_tmr_en", 32'(Tmr_en), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
            pulse_end();
            if (Irq === 1'b1) irq_pulses++;
            check($sformatf("per_%0d_rearm_tmr_rst", i), 32'(Tmr_rst), 1);
            check($sformatf("per_%0d_rearm_tmr_en", i), 32'(Tmr_en), 0);
            pulse_ack();
            check($sformatf("per_%0d_run_tmr_rst", i), 32'(Tmr_rst), 0);
            check($sformatf("per_%0d_run_tmr_en", i), 32'(Tmr_en), 1);
            check($sformatf("per_%0d_irq_cleared", i), 32'(Irq), 0);
        end
        check("per_irq_pulses", 32'(irq_pulses), 3);
        check("per_ovf", 32'(Ovf_cnt), 0);

        // Collision: event and ack together with pend set
        pulse_end();
        tick();
        check("col_pend_before", 32'(Irq), 1);
        check("col_run", 32'(Dbg_state), 32'(ST_RUN));
        Tmr_end = 1'b1;
        Irq_ack = 1'b1;
        tick();
        Tmr_end = 1'b0;
        Irq_ack = 1'b0;
        check("col_pend_kept", 32'(Irq), 1);
        check("col_ovf_unchanged", 32'(Ovf_cnt), 0);
        check("col_rearm", 32'(Dbg_state), 32'(ST_ARM));
        tick();

        // Overflow: 20 unacknowledged events, pend already set
        for (int i = 0; i < 20; i++) begin
            pulse_end();
            check($sformatf("ovf_cnt_%0d", i), 32'(Ovf_cnt), (i + 1 > 15) ? 15 : i + 1);
            tick();
        end
        check("ovf_irq_held", 32'(Irq), 1);
        wr(A_CTRL, 32'b111);
        check("ovf_start_clears", 32'(Ovf_cnt), 0);
        check("ovf_start_keeps_irq", 32'(Irq), 1);
        check("ovf_start_arm", 32'(Dbg_state), 32'(ST_ARM));
        tick();
        pulse_ack();
        check("ovf_ack_irq", 32'(Irq), 0);

        // Abort with STOP while running
        wr(A_LOAD, 32'd7);
        check("abort_load_visible", Tmr_load, 7);
        check("abort_still_run", 32'(Dbg_state), 32'(ST_RUN));
        pulse_end();
        tick();
        wr(A_STOP, 32'hDEAD);
        check("abort_tmr_en", 32'(Tmr_en), 0);
        check("abort_busy", 32'(Busy), 0);
        check("abort_pend_kept", 32'(Irq), 1);
        pulse_end();
        check("abort_end_ignored_state", 32'(Dbg_state), 32'(ST_IDLE));
        check("abort_end_ignored_ovf", 32'(Ovf_cnt), 0);
        pulse_ack();
        check("abort_ack_irq", 32'(Irq), 0);

        // Reserved address has no effect
        wr(A_RSVD, 32'hFFFF_FFFF);
        check("rsvd_load", Tmr_load, 7);
        check("rsvd_state", 32'(Dbg_state), 32'(ST_IDLE));

        // Reset in RUN with pend set; reset also dominates a write
        wr(A_CTRL, 32'b111);
        tick();
        pulse_end();
        tick();
        check("rrun_irq_before", 32'(Irq), 1);
        check("rrun_state_before", 32'(Dbg_state), 32'(ST_RUN));
        Rst = 1'b1;
        Wr_en = 1'b1;
        Wr_addr = A_LOAD;
        Wr_data = 32'hAA;
        #1;
        check("rrun_tmr_rst_comb", 32'(Tmr_rst), 1);
        tick();
        Wr_en = 1'b0;
        check("rrun_tmr_en", 32'(Tmr_en), 0);
        check("rrun_irq", 32'(Irq), 0);
        check("rrun_ovf", 32'(Ovf_cnt), 0);
        check("rrun_busy", 32'(Busy), 0);
        check("rrun_load", Tmr_load, 0);
        Rst = 1'b0;
        tick();

        // Power-off in RUN
        wr(A_LOAD, 32'd9);
        wr(A_CTRL, 32'b111);
        tick();
        pulse_end();
        tick();
        check("pwr_run_before", 32'(Dbg_state), 32'(ST_RUN));
        Pwr_off = 1'b1;
        #1;
        check("pwr_tmr_en_held", 32'(Tmr_en), 0);
        tick();
        check("pwr_state", 32'(Dbg_state), 32'(ST_IDLE));
        check("pwr_irq", 32'(Irq), 0);
        check("pwr_load_kept", Tmr_load, 9);
        wr(A_CTRL, 32'b111);
        check("pwr_start_ignored", 32'(Busy), 0);
        wr(A_LOAD, 32'd5);
        check("pwr_load_ignored", Tmr_load, 9);
        Pwr_off = 1'b0;
        tick();
        wr(A_CTRL, 32'b101);
        check("pwr_ctrl_after_release", 32'(Dbg_state), 32'(ST_ARM));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_evt_ctrl.md
TIMER_EVT_CTRL -- requirements
Module: timer_evt_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the timer width and the width of Tmr_load and Wr_data.
REQ-002 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Rst  input  1  reset, synchronous and active-high.
REQ-004 Pwr_off  input  1  synchronous power-off hold.
REQ-005 Wr_en  input  1  configuration write strobe, one write per cycle.
REQ-006 Wr_addr  input  2  write target: 0=LOAD, 1=CTRL, 2=STOP, 3=reserved.
REQ-007 Wr_data  input  N  write data.
REQ-008 Tmr_end  input  1  end-of-count pulse from the downstream Timer.
REQ-009 Irq_ack  input  1  interrupt acknowledge, level sampled per cycle.
REQ-010 Tmr_en  output  1  count enable to the Timer.
REQ-011 Tmr_rst  output  1  restart to the Timer; reloads the tick register and clears the counter.
REQ-012 Tmr_load  output  N  tick value to the Timer (X ticks = X-1).
REQ-013 Irq  output  1  interrupt request.
REQ-014 Ovf_cnt  output  4  count of missed events.
REQ-015 Busy  output  1  high when the FSM is not in IDLE.

Function
REQ-016 The block SHALL hold registers: load_r (N bits), and ctrl_r with periodic (Wr_data[1]) and irq_en (Wr_data[2]).
- Tmr_load SHALL equal load_r.
- A write to LOAD updates load_r next cycle.
- The new value reaches the Timer only at the next Tmr_rst.
REQ-017 The FSM SHALL have states IDLE, ARM, RUN and DONE.
REQ-018 A CTRL write updates ctrl_r. If Wr_data[0]=1 (start), then from any state:
- The next state SHALL be ARM.
- Ovf_cnt SHALL be cleared.
- pend is not affected.
REQ-019 A STOP write, any data, from any state SHALL cause the next state to be IDLE; pend and Ovf_cnt are retained.
REQ-020 In ARM: Tmr_rst=1 and Tmr_en=0 for exactly one cycle, then RUN.
REQ-021 In RUN, Tmr_en=1 and Tmr_rst=0. When Tmr_end=1, pend SHALL be set, and the next state SHALL be:
- ARM if periodic=1;
- DONE if periodic=0.
REQ-022 In DONE, Tmr_en=0. The next state SHALL be IDLE on an Irq_ack=1 cycle with pend set, or ARM on a start write. Otherwise it stays in DONE.
REQ-023 Tmr_end outside RUN SHALL be ignored.
REQ-024 Irq SHALL equal pend AND irq_en and be registered.
- Latency: Tmr_end sampled at edge t gives Irq=1 from cycle t+1.
REQ-025 Irq_ack=1 SHALL clear pend at the next edge.
- If Tmr_end (in RUN) and Irq_ack occur in the same cycle, pend SHALL remain 1 and Ovf_cnt SHALL NOT increment.
REQ-026 Tmr_end in RUN while pend=1 and Irq_ack=0 SHALL increment Ovf_cnt, saturating at 15.
REQ-027 Start latency: a start write sampled at edge t gives Tmr_rst=1 in cycle t+1 and Tmr_en=1 from cycle t+2.
REQ-028 Busy SHALL be 1 in ARM, RUN and DONE.
REQ-029 Writes to Wr_addr=3 SHALL have no effect.
REQ-030 Pwr_off=1 (Rst=0) SHALL:
- force the state to IDLE and clear pend and Ovf_cnt;
- retain load_r and ctrl_r;
- ignore writes and Tmr_end;
- hold Tmr_en=0.

Reset
REQ-031 Rst SHALL dominate Pwr_off and all writes.
REQ-032 At the edge where Rst=1, the block SHALL clear load_r, ctrl_r, pend and Ovf_cnt, and set the state to IDLE.
REQ-033 After reset, the outputs SHALL be Tmr_en=0, Irq=0, Ovf_cnt=0, Busy=0 and Tmr_load=0.
REQ-034 Tmr_rst SHALL be 1 whenever Rst=1 (Tmr_rst = Rst OR state==ARM), so the Timer is restarted with the block.
REQ-035 Rst asserted in RUN or DONE SHALL abort the state to IDLE on the next edge with Irq=0.

Verification
REQ-036 One-shot:
- Stimulus: LOAD=3; CTRL=0b101; Tmr_end pulse 4 cycles after Tmr_en rises.
- Response: Tmr_rst one cycle, then Tmr_en=1; after the pulse, Irq=1, Tmr_en=0, state DONE.
- Then Irq_ack one cycle: Irq=0, Busy=0.
REQ-037 Periodic:
- Stimulus: CTRL=0b111; three Tmr_end pulses, each acked before the next.
- Response: each pulse is followed by exactly one Tmr_rst cycle, then Tmr_en=1; Irq pulses three times; Ovf_cnt=0.
REQ-038 Overflow:
- Stimulus: periodic mode, no ack, 20 Tmr_end pulses.
- Response: Ovf_cnt saturates at 15; Irq stays 1.
- Then a start write: Ovf_cnt=0.
REQ-039 Collision:
- Stimulus: Tmr_end and Irq_ack in the same cycle with pend=1.
- Response: pend stays 1; Ovf_cnt unchanged.
REQ-040 Abort:
- Stimulus: STOP write in RUN.
- Response: Tmr_en=0 and Busy=0 next cycle; pend kept; LOAD=7 written in RUN does not change Tmr_load behaviour until the next ARM.
REQ-041 Reset and power-off:
- Stimulus 1: Rst in RUN with pend=1.
- Response 1: all outputs at reset values next cycle; Tmr_rst=1 during Rst.
- Stimulus 2: Pwr_off in RUN.
- Response 2: IDLE; load_r retained (Tmr_load unchanged).
